server_rx_monitor: RTL
======================

// Module: server_rx_monitor
// PURPOSE
//  Receive-side sink and checker for server test traffic, paired with the server traffic generator.
//  Takes the 64-bit AXIS stream arriving at a server port and parses the generator frame format:
//    beat0 = {dst_mac, src_mac[47:32]}; beat1 = {src_mac[31:0], 16'h0800, 16'h0}; beats 2..N-1 = tx timestamp.
//  For each frame: checks it, measures one-way latency against the local timestamp, reports a per-frame
//  result and keeps saturating statistics.
// PARAMETERS
//  P_MY_PORT_MAC  48'h8D_BC_5C_4A_00_01  expected destination MAC of every received frame
//  P_PKT_LEN      128                    expected frame length in beats
//  P_ETHERTYPE    16'h0800               expected ethertype in beat1[31:16]
// PORTS
//  i_clk             in   1   clock
//  i_rst             in   1   reset, asynchronous, active-high
//  i_stat_rx_status  in   1   link up; beats are ignored while low
//  i_time_stamp      in   64  local free-running time, same timebase as the transmitter
//  i_clr_stats       in   1   synchronous clear of counters and o_lat_max
//  rx_axis_tvalid    in   1   AXIS valid
//  rx_axis_tdata     in   64  AXIS data
//  rx_axis_tlast     in   1   AXIS last
//  rx_axis_tkeep     in   8   AXIS keep; must be 8'hFF on every beat
//  rx_axis_tuser     in   1   AXIS error marker, sampled on the tlast beat
//  rx_axis_tready    out  1   constant 1 (pure sink, no backpressure)
//  o_pkt_valid       out  1   one-cycle per-frame result strobe
//  o_pkt_ok          out  1   frame passed all checks (qualified by o_pkt_valid)
//  o_err_flags       out  5   [0]dst [1]type [2]len [3]user/keep [4]abort
//  o_src_mac         out  48  source MAC of the reported frame
//  o_latency         out  64  i_time_stamp minus tx timestamp, captured at beat2
//  o_pkt_cnt         out  32  frames reported with o_pkt_ok=1
//  o_err_cnt         out  32  frames reported with o_pkt_ok=0
//  o_lat_max         out  64  maximum o_latency over OK frames
// BEHAVIOUR
//  - Reset: every output 0 except rx_axis_tready; FSM in S_IDLE; beat counter 0.
//  - Accepted beat = tvalid & i_stat_rx_status; the beat counter (16b) increments per beat and clears after tlast.
//  - FSM:
//      S_IDLE  -> S_HDR1 on beat0 without tlast.
//      S_HDR1  -> S_DATA on beat1 without tlast.
//      S_DATA  -> S_IDLE on tlast.
//      tlast in any state -> S_IDLE.
//  - beat0: dst = tdata[63:16], src_hi = tdata[15:0]; dst != P_MY_PORT_MAC sets err[0].
//  - beat1: src_lo = tdata[63:32]; tdata[31:16] != P_ETHERTYPE sets err[1].
//  - beat2: latency = i_time_stamp - tdata, modulo 2^64 (wraps, no sign handling).
//    Later timestamp beats are not checked.
//  - err[2] set if the beat count at tlast != P_PKT_LEN. A frame that runs past P_PKT_LEN without tlast
//    keeps being consumed until tlast. A frame shorter than 3 beats reports latency 0.
//  - err[3] set on tkeep != 8'hFF on any beat, or tuser=1 on the tlast beat.
//  - Result: registered; o_pkt_valid pulses exactly 1 cycle after the tlast beat.
//    o_src_mac, o_latency, o_err_flags and o_pkt_ok hold until the next pulse.
//  - Back-to-back frames: beat0 of the next frame is accepted in the cycle right after tlast.
//    Reporting never stalls parsing.
//  - i_stat_rx_status falling mid-frame (state != S_IDLE): frame aborted and FSM -> S_IDLE;
//    o_pkt_valid pulses next cycle with err[4]=1 plus any flags already set.
//  - Counters update in the same cycle as o_pkt_valid and saturate at 32'hFFFF_FFFF.
//    o_lat_max updates only for OK frames.
//  - i_clr_stats has priority: a frame completing in the same cycle is not counted and not folded into o_lat_max.
//    Its o_pkt_valid strobe is still issued.
//  - Reset mid-frame: everything returns to reset values. The remainder of the frame arrives in S_IDLE:
//    its first beat is parsed as beat0, so the frame reports err[0]/err[1]/err[2] as the data dictates.
// STRUCTURE
//  - Package server_pkt_pkg:
//      P_PKT_LEN, P_ETHERTYPE;
//      err-flag bit indices (ERR_DST=0, ERR_TYPE=1, ERR_LEN=2, ERR_USER=3, ERR_ABORT=4);
//      FSM state encodings (S_IDLE, S_HDR1, S_DATA).
//    The traffic generator imports the same constants.
//  - One sub-module, sat_counter #(W=32): inc, clr (priority), saturating count.
//    Instantiated twice, for o_pkt_cnt and o_err_cnt.
// TESTING
//  1. One 128-beat frame, dst=P_MY_PORT_MAC, src=48'h8D_BC_5C_4A_03_02, beat2=1000, local ts at beat2=1250
//     -> o_pkt_valid 1 cycle after tlast, o_pkt_ok=1, o_latency=250, o_src_mac=...03_02, o_pkt_cnt=1.
//  2. dst=...00_02, ethertype 16'h86DD -> o_err_flags=5'b00011, o_err_cnt=1, o_pkt_cnt unchanged.
//  3. Frame with tlast on beat 100, then frame with tlast on beat 140
//     -> both report err[2]=1; beat0 of the second frame accepted the cycle after the first tlast.
//  4. Beat2=64'hFFFF_FFFF_FFFF_FFF0, local ts=64'h10 -> o_latency=64'h20.
//     Then a latency-5 OK frame -> o_lat_max stays 64'h20.
//  5. i_stat_rx_status dropped at beat 50 -> o_pkt_valid next cycle with err[4]=1.
//     Next full frame after link up -> OK.
//  6. i_clr_stats asserted in the cycle a good frame completes -> o_pkt_cnt=0, o_lat_max=0, o_pkt_valid still pulses.
//     Preload a counter at 32'hFFFF_FFFF -> stays saturated.

Source files
------------

// File: rtl/server_pkt_pkg.sv
// Shared constants for the server test-traffic generator and receive monitor:
// frame geometry, error-flag bit positions and parser state encoding.
package server_pkt_pkg;

    localparam int unsigned P_PKT_LEN   = 128;
    localparam logic [15:0] P_ETHERTYPE = 16'h0800;

    localparam int unsigned ERR_W     = 5;
    localparam int unsigned ERR_DST   = 0;
    localparam int unsigned ERR_TYPE  = 1;
    localparam int unsigned ERR_LEN   = 2;
    localparam int unsigned ERR_USER  = 3;
    localparam int unsigned ERR_ABORT = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR1 = 2'd1,
        S_DATA = 2'd2
    } rx_state_e;

endpackage

// File: rtl/server_rx_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule

// File: rtl/server_rx_monitor.sv
// Receive-side sink for generator frames: parses header and tx timestamp, checks
// the frame, reports a registered per-frame result and keeps saturating statistics.
module server_rx_monitor #(
    parameter logic [47:0] P_MY_PORT_MAC = 48'h8D_BC_5C_4A_00_01,
    parameter int unsigned P_PKT_LEN     = server_pkt_pkg::P_PKT_LEN,
    parameter logic [15:0] P_ETHERTYPE   = server_pkt_pkg::P_ETHERTYPE
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stat_rx_status,
    input  logic [63:0] i_time_stamp,
    input  logic        i_clr_stats,
    input  logic        rx_axis_tvalid,
    input  logic [63:0] rx_axis_tdata,
    input  logic        rx_axis_tlast,
    input  logic [7:0]  rx_axis_tkeep,
    input  logic        rx_axis_tuser,
    output logic        rx_axis_tready,
    output logic        o_pkt_valid,
    output logic        o_pkt_ok,
    output logic [4:0]  o_err_flags,
    output logic [47:0] o_src_mac,
    output logic [63:0] o_latency,
    output logic [31:0] o_pkt_cnt,
    output logic [31:0] o_err_cnt,
    output logic [63:0] o_lat_max
);

    import server_pkt_pkg::*;

    localparam logic [15:0] LEN16 = 16'(P_PKT_LEN);

    rx_state_e         state_q,     state_d;
    logic [15:0]       beat_cnt_q,  beat_cnt_d;
    logic [15:0]       src_hi_q,    src_hi_d;
    logic [31:0]       src_lo_q,    src_lo_d;
    logic [63:0]       lat_q,       lat_d;
    logic [ERR_W-1:0]  err_q,       err_d;

    logic              pkt_valid_q, pkt_valid_d;
    logic              pkt_ok_q,    pkt_ok_d;
    logic [ERR_W-1:0]  err_flags_q, err_flags_d;
    logic [47:0]       src_mac_q,   src_mac_d;
    logic [63:0]       latency_q,   latency_d;
    logic [63:0]       lat_max_q,   lat_max_d;

    logic              accept;
    logic              done;
    logic              frame_ok;
    logic [15:0]       beat_num;

    assign accept   = rx_axis_tvalid & i_stat_rx_status;
    assign beat_num = beat_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        src_hi_d   = src_hi_q;
        src_lo_d   = src_lo_q;
        lat_d      = lat_q;
        err_d      = err_q;
        done       = 1'b0;

        if ((state_q != S_IDLE) && !i_stat_rx_status) begin
            err_d[ERR_ABORT] = 1'b1;
            done             = 1'b1;
            state_d          = S_IDLE;
            beat_cnt_d       = '0;
        end else if (accept) begin
            beat_cnt_d = beat_num;
            unique case (state_q)
                S_IDLE: begin
                    // Every field is re-seeded here so short frames report clean zeros
                    err_d           = '0;
                    src_lo_d        = '0;
                    lat_d           = '0;
                    src_hi_d        = rx_axis_tdata[15:0];
                    err_d[ERR_DST]  = (rx_axis_tdata[63:16] != P_MY_PORT_MAC);
                    state_d         = S_HDR1;
                end
                S_HDR1: begin
                    src_lo_d = rx_axis_tdata[63:32];
                    if (rx_axis_tdata[31:16] != P_ETHERTYPE) begin
                        err_d[ERR_TYPE] = 1'b1;
                    end
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (beat_cnt_q == 16'd2) begin
                        lat_d = i_time_stamp - rx_axis_tdata;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (rx_axis_tkeep != 8'hFF) begin
                err_d[ERR_USER] = 1'b1;
            end

            if (rx_axis_tlast) begin
                if (rx_axis_tuser) begin
                    err_d[ERR_USER] = 1'b1;
                end
                if (beat_num != LEN16) begin
                    err_d[ERR_LEN] = 1'b1;
                end
                done       = 1'b1;
                state_d    = S_IDLE;
                beat_cnt_d = '0;
            end
        end
    end

    assign frame_ok = done && (err_d == '0);

    always_comb begin
        pkt_valid_d = done;
        pkt_ok_d    = pkt_ok_q;
        err_flags_d = err_flags_q;
        src_mac_d   = src_mac_q;
        latency_d   = latency_q;
        lat_max_d   = lat_max_q;

        if (done) begin
            pkt_ok_d    = frame_ok;
            err_flags_d = err_d;
            src_mac_d   = {src_hi_d, src_lo_d};
            latency_d   = lat_d;
        end

        if (i_clr_stats) begin
            lat_max_d = '0;
        end else if (frame_ok && (lat_d > lat_max_q)) begin
            lat_max_d = lat_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            src_hi_q    <= '0;
            src_lo_q    <= '0;
            lat_q       <= '0;
            err_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_ok_q    <= 1'b0;
            err_flags_q <= '0;
            src_mac_q   <= '0;
            latency_q   <= '0;
            lat_max_q   <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            src_hi_q    <= src_hi_d;
            src_lo_q    <= src_lo_d;
            lat_q       <= lat_d;
            err_q       <= err_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_ok_q    <= pkt_ok_d;
            err_flags_q <= err_flags_d;
            src_mac_q   <= src_mac_d;
            latency_q   <= latency_d;
            lat_max_q   <= lat_max_d;
        end
    end

    sat_counter #(.W(32)) u_pkt_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (frame_ok),
        .i_clr   (i_clr_stats),
        .o_count (o_pkt_cnt)
    );

    sat_counter #(.W(32)) u_err_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (done && !frame_ok),
        .i_clr   (i_clr_stats),
        .o_count (o_err_cnt)
    );

    assign rx_axis_tready = 1'b1;
    assign o_pkt_valid    = pkt_valid_q;
    assign o_pkt_ok       = pkt_ok_q;
    assign o_err_flags    = err_flags_q;
    assign o_src_mac      = src_mac_q;
    assign o_latency      = latency_q;
    assign o_lat_max      = lat_max_q;

endmodule
